// File: rtl/muldiv_if.sv
// Execute/decode-side handshake bundle for the HI/LO multiply/divide sequencer.
// The master drives the issue and hazard inputs; the slave returns HI/LO and status.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start_e;
  logic [1:0]       op_e;
  logic [WIDTH-1:0] src_a_e;
  logic [WIDTH-1:0] src_b_e;
  logic             mthi_e;
  logic             mtlo_e;
  logic             hilo_use_d;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             stall_d;

  modport master (
    output start_e, op_e, src_a_e, src_b_e, mthi_e, mtlo_e, hilo_use_d,
    input  hi, lo, busy, done, div_zero, stall_d
  );

  modport slave (
    input  start_e, op_e, src_a_e, src_b_e, mthi_e, mtlo_e, hilo_use_d,
    output hi, lo, busy, done, div_zero, stall_d
  );
endinterface

// File: rtl/muldiv_controller.sv
// Iterative 1-bit/cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with decode stall.
// Define MULDIV_EARLY_OUT_EN to end MUL once the remaining multiplier bits are all zero.
module muldiv_controller #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave mdu
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  state_t             r_state;
  logic               r_busy, r_done, r_dz_pulse;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_sa, r_neg, r_dz;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [WIDTH-1:0]   r_mplier, r_b, r_a_raw;

  logic               w_sa_in, w_sb_in, w_b_zero;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_mplier_nxt, w_quot, w_rem;
  logic [WIDTH:0]     w_shift, w_diff;
  logic [2*WIDTH-1:0] w_prod;

  assign w_sa_in      = ~mdu.op_e[0] & mdu.src_a_e[WIDTH-1];
  assign w_sb_in      = ~mdu.op_e[0] & mdu.src_b_e[WIDTH-1];
  assign w_abs_a      = cneg_w(mdu.src_a_e, w_sa_in);
  assign w_abs_b      = cneg_w(mdu.src_b_e, w_sb_in);
  assign w_b_zero     = (mdu.src_b_e == '0);
  assign w_mplier_nxt = r_mplier >> 1;
  // r_mplier doubles as the quotient shift register during DIV; r_acc low half is the remainder.
  assign w_shift      = {r_acc[WIDTH-1:0], r_mplier[WIDTH-1]};
  assign w_diff       = w_shift - {1'b0, r_b};
  assign w_prod       = cneg_2w(r_acc, r_neg);
  assign w_quot       = cneg_w(r_mplier, r_neg);
  assign w_rem        = cneg_w(r_acc[WIDTH-1:0], r_sa);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dz_pulse <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_sa       <= 1'b0;
      r_neg      <= 1'b0;
      r_dz       <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_dz_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mdu.start_e) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= mdu.op_e[1];
            r_sa     <= w_sa_in;
            r_neg    <= w_sa_in ^ w_sb_in;
            r_dz     <= mdu.op_e[1] & w_b_zero;
            if (w_b_zero && (mdu.op_e[1] || EARLY_OUT)) r_state <= S_FIX;
            else if (mdu.op_e[1])                       r_state <= S_DIV;
            else                                        r_state <= S_MUL;
          end else begin
            if (mdu.mthi_e) r_hi <= mdu.src_a_e;
            if (mdu.mtlo_e) r_lo <= mdu.src_a_e;
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST || (EARLY_OUT && w_mplier_nxt == '0)) r_state <= S_FIX;
        end
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_dz_pulse <= r_dz;
          r_state    <= S_IDLE;
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_dz) begin
            r_hi <= r_a_raw;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath: operand magnitudes latched at accept, one shift-add or restoring step per cycle
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (mdu.start_e) begin
          r_acc    <= '0;
          r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
          r_b      <= w_abs_b;
          r_mplier <= mdu.op_e[1] ? w_abs_a : w_abs_b;
          r_a_raw  <= mdu.src_a_e;
        end
      end
      S_MUL: begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= w_mplier_nxt;
      end
      S_DIV: begin
        r_acc[WIDTH-1:0] <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_mplier         <= {r_mplier[WIDTH-2:0], ~w_diff[WIDTH]};
      end
      default: ;
    endcase
  end

  assign mdu.hi       = r_hi;
  assign mdu.lo       = r_lo;
  assign mdu.busy     = r_busy;
  assign mdu.done     = r_done;
  assign mdu.div_zero = r_dz_pulse;
  assign mdu.stall_d  = (r_busy | mdu.start_e) & mdu.hilo_use_d;
endmodule
